// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with HI/LO result registers.
// Multiply is magnitude shift-add, divide is restoring; both use WIDTH iterations plus a final sign fix.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi_out,
    output logic [WIDTH-1:0] o_lo_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        abs_w = v[WIDTH-1] ? neg_w(v) : v;
    endfunction

    state_t           r_state;
    logic             r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    // One shift-add (multiply) or restore-subtract (divide) step, plus the sign-corrected result
    always_comb begin
        w_sum    = {1'b0, r_acc} + {1'b0, r_m};
        w_shift  = {r_acc, r_q[WIDTH-1]};
        w_trial  = w_shift - {1'b0, r_m};
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        if (r_op == 1'b0) begin
            if (r_q[0]) begin
                w_acc_nx = w_sum[WIDTH:1];
                w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
            end else begin
                w_acc_nx = {1'b0, r_acc[WIDTH-1:1]};
                w_q_nx   = {r_acc[0], r_q[WIDTH-1:1]};
            end
        end else begin
            // A borrow out of the trial subtraction means the divisor did not fit: restore
            if (w_trial[WIDTH]) begin
                w_acc_nx = w_shift[WIDTH-1:0];
                w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
            end else begin
                w_acc_nx = w_trial[WIDTH-1:0];
                w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
            end
        end
        w_prod = r_neg_q ? neg_2w({w_acc_nx, w_q_nx}) : {w_acc_nx, w_q_nx};
        if (r_op == 1'b0) begin
            w_hi_res = w_prod[2*WIDTH-1:WIDTH];
            w_lo_res = w_prod[WIDTH-1:0];
        end else begin
            w_hi_res = r_neg_r ? neg_w(w_acc_nx) : w_acc_nx;
            w_lo_res = r_neg_q ? neg_w(w_q_nx) : w_q_nx;
        end
    end

    // Control FSM, datapath iteration and registered outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_op       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_acc      <= {WIDTH{1'b0}};
            r_q        <= {WIDTH{1'b0}};
            r_m        <= {WIDTH{1'b0}};
            r_hi       <= {WIDTH{1'b0}};
            r_lo       <= {WIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        if (i_op && (i_b == {WIDTH{1'b0}})) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state    <= S_RUN;
                            r_op       <= i_op;
                            r_neg_q    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                            r_neg_r    <= i_a[WIDTH-1];
                            r_cnt      <= CNT_LOAD;
                            r_acc      <= {WIDTH{1'b0}};
                            r_q        <= abs_w(i_a);
                            r_m        <= abs_w(i_b);
                            r_div_zero <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_hi    <= w_hi_res;
                        r_lo    <= w_lo_res;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_hi_out   = r_hi;
    assign o_lo_out   = r_lo;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 64-bit arithmetic model predicts HI/LO/div_zero per start.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic         i_op;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [W-1:0] o_hi_out;
    logic [W-1:0] o_lo_out;
    logic         o_busy;
    logic         o_done;
    logic         o_div_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    int           n_checks = 0;
    int           n_errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_hi_out   (o_hi_out),
        .o_lo_out   (o_lo_out),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sbv;
        longint p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dz = 1'b0;
        if (op && (b == 32'd0)) begin
            e.dz = 1'b1;
        end else if (!op) begin
            p = sa * sbv;
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else begin
            p    = sa / sbv;
            m_lo = p[31:0];
            p    = sa % sbv;
            m_hi = p[31:0];
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit b2b, input bit interfere);
        int   cyc;
        int   nbusy;
        exp_t e;
        if (!b2b) @(negedge clk);
        push_exp(op, a, b);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(negedge clk);
        i_start = 1'b0;
        cyc     = 1;
        nbusy   = 0;
        while (!o_done && cyc < 200) begin
            if (o_busy) nbusy++;
            i_a  = $urandom;
            i_b  = $urandom;
            i_op = 1'($urandom);
            i_start = (interfere && cyc == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        e = sb_q.pop_front();
        check_val("latency", 64'(cyc), e.dz ? 64'd1 : 64'd33);
        check_val("busy_cycles", 64'(nbusy), e.dz ? 64'd0 : 64'd32);
        check_val("busy_at_done", 64'(o_busy), 64'd0);
        check_val("hi", 64'(o_hi_out), 64'(e.hi));
        check_val("lo", 64'(o_lo_out), 64'(e.lo));
        check_val("div_zero", 64'(o_div_zero), 64'(e.dz));
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_op    = 1'b0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        #12;
        check_val("rst_hi", 64'(o_hi_out), 64'd0);
        check_val("rst_lo", 64'(o_lo_out), 64'd0);
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_done", 64'(o_done), 64'd0);
        check_val("rst_dz", 64'(o_div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0);
        check_val("mul_neg_hi_const", 64'(o_hi_out), 64'hFFFFFFFF);
        check_val("mul_neg_lo_const", 64'(o_lo_out), 64'hFFFFFFEB);
        @(negedge clk);
        check_val("done_single", 64'(o_done), 64'd0);
        run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        check_val("minmin_hi_const", 64'(o_hi_out), 64'h40000000);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        check_val("div_neg_lo_const", 64'(o_lo_out), 64'hFFFFFFFD);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        check_val("min_m1_lo_const", 64'(o_lo_out), 64'h80000000);

        // 0x66 * 0x2AAAAAAB = 0x11_00000022
        run_op(1'b0, 32'h66, 32'h2AAAAAAB, 1'b0, 1'b0);
        check_val("preload_hi", 64'(o_hi_out), 64'h11);
        check_val("preload_lo", 64'(o_lo_out), 64'h22);
        run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        check_val("dz_hi_kept", 64'(o_hi_out), 64'h11);
        @(negedge clk);
        check_val("dz_level_held", 64'(o_div_zero), 64'd1);
        check_val("dz_done_pulse", 64'(o_done), 64'd0);

        run_op(1'b0, 32'hFFFFFF9C, 32'd12345, 1'b0, 1'b1);
        run_op(1'b1, 32'd1000, 32'hFFFFFFF9, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_op(1'($urandom), 32'($urandom), (i % 4 == 3) ? 32'd0 : 32'($urandom),
                   bit'(i % 2), bit'(i == 4));
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        i_start = 1'b1;
        i_op    = 1'b0;
        i_a     = 32'hDEAD;
        i_b     = 32'hBEEF;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", 64'(o_busy), 64'd0);
        check_val("arst_done", 64'(o_done), 64'd0);
        check_val("arst_hi", 64'(o_hi_out), 64'd0);
        check_val("arst_lo", 64'(o_lo_out), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'h12345, 32'hFFFFF889, 1'b0, 1'b0);

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
